// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds a registered div_zero_o flag.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  div_zero_o
`endif
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  // {remainder, partial dividend/quotient, 1} layout: remainder ends in [2W:W+1], quotient in [W-1:0]
  logic [2*DATA_W:0]     work;
  logic [DATA_W-1:0]     divisor;
  logic                  sign1;
  logic                  sign2;
  logic                  sgn;
  logic [2*DATA_W-1:0]   res;
`ifdef DIV_ZERO_FLAG_EN
  logic                  zflag;
`endif

  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     rem;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  always_comb begin
    trial   = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;
    quo     = work[DATA_W-1:0];
    rem     = work[2*DATA_W:DATA_W+1];
    quo_fix = (sgn && (sign1 ^ sign2)) ? ('0 - quo) : quo;
    rem_fix = (sgn && sign1) ? ('0 - rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sgn      <= 1'b0;
      res      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      zflag      <= 1'b0;
      div_zero_o <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_o <= 1'b0;
`endif
          if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FLAG_EN
            zflag <= (opdata2_i == '0);
`endif
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              work    <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
              divisor <= op2_abs;
              sign1   <= opdata1_i[DATA_W-1];
              sign2   <= opdata2_i[DATA_W-1];
              sgn     <= signed_div_i;
            end
          end
        end

        BYZERO: begin
          ready_o <= 1'b0;
          if (annul_i) begin
            state <= FREE;
          end else begin
            res   <= '0;
            state <= END;
          end
        end

        ON: begin
          ready_o <= 1'b0;
          if (annul_i) begin
            state <= FREE;
          end else if (cnt != CNT_W'(DATA_W)) begin
            if (trial[DATA_W])
              work <= {work[2*DATA_W-1:0], 1'b0};
            else
              work <= {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt <= cnt + CNT_W'(1);
          end else begin
            res   <= {rem_fix, quo_fix};
            cnt   <= '0;
            state <= END;
          end
        end

        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= res;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= zflag;
`endif
          end else begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit: latency, results, hold/release, annul and mid-run reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for ready_o after an accept edge; returns number of edges counted from the accept edge.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (!ready_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input vec_t v, input string name);
    int lat;
    logic [63:0] held;
    @(negedge clk);
    signed_div_i = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    check({name, " ready"}, {63'b0, ready_o}, 64'd1);
    check({name, " result"}, result_o, {v.r, v.q});
`ifdef DIV_ZERO_FLAG_EN
    check({name, " div_zero"}, {63'b0, div_zero_o}, {63'b0, (v.b == 32'd0)});
`endif
    held = result_o;
    @(posedge clk); #1;
    check({name, " held ready"}, {63'b0, ready_o}, 64'd1);
    check({name, " held result"}, result_o, {v.r, v.q});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " drop ready"}, {63'b0, ready_o}, 64'd0);
    check({name, " drop result"}, result_o, 64'd0);
    if (held !== {v.r, v.q}) $display("note: %s held value differs", name);
  endtask

  initial begin
    int lat;
    bit saw_ready;

    vecs[0] = '{1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, 35};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 35};
    vecs[2] = '{1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC, 32'h00000001, 35};
    vecs[3] = '{1'b0, 32'd1234,      32'd0,         32'h00000000, 32'h00000000, 3};
    vecs[4] = '{1'b1, 32'h80000000,  32'd0,         32'h00000000, 32'h00000000, 3};
    vecs[5] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 35};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF, 32'h00000000, 35};
    vecs[7] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 35};

    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'b0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // Annul mid-division: ready must never rise, then a fresh 9/3 runs with full latency.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul no ready", {63'b0, saw_ready}, 64'd0);
    run_div('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35}, "post-annul 9/3");

    // Reset at E20 with start held high: outputs clear, then a new division completes.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst ready", {63'b0, ready_o}, 64'd0);
    check("midrst result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wait_ready(lat);
    check("post-rst latency", 64'(lat), 64'd35);
    check("post-rst result", result_o, 64'h00000002_0000000E);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("post-rst drop ready", {63'b0, ready_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
